// File: rtl/video_pattern_checker_pkg.sv
// Shared definitions for the video colour-block pattern source and checker.
// Contents:
//   DEF_* defaults for block length, colours and loss threshold
//   LFSR_SEED and lfsr_next() for the 8-bit throttle LFSR (x^8+x^6+x^5+x^4+1)
//   chk_state_t checker state encoding
//   sat_inc16() saturating 16-bit increment
package video_pattern_checker_pkg;

  localparam int unsigned DEF_BLOCK_LEN   = 128;
  localparam logic [23:0] DEF_COLOR_A     = 24'h1ABC9C;
  localparam logic [23:0] DEF_COLOR_B     = 24'hE67E22;
  localparam int unsigned DEF_LOSS_THRESH = 4;

  localparam logic [7:0]  LFSR_SEED       = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } chk_state_t;

  // Fibonacci form: shift left, new bit enters at bit 0 from taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/video_pattern_checker_if.sv
// Pixel stream handshake between a pattern source and the checker.
// Signals:
//   Video      : 24-bit {R,G,B} pixel, driven by the source every cycle
//   VideoReady : pixel is consumed this cycle; the source advances on it
// Modports:
//   master : pattern source side
//   slave  : checker side
interface video_pattern_checker_if;

  logic [23:0] Video;
  logic        VideoReady;

  modport master (output Video, input VideoReady);
  modport slave  (input Video, output VideoReady);

endinterface

// File: rtl/video_pattern_checker_ready_lfsr.sv
// Free-running 8-bit maximal LFSR used to generate pseudo-random backpressure.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, loads LFSR_SEED
//   rnd : bit 0 of the current LFSR state
module ready_lfsr
  import video_pattern_checker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic rnd
);

  logic [7:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

  assign rnd = q[0];

endmodule

// File: rtl/video_pattern_checker.sv
// Colour-block pattern checker. The source emits BLOCK_LEN pixels of COLOR_A,
// then BLOCK_LEN of COLOR_B, alternating. The checker tracks block position,
// counts mismatches and completed blocks, and re-acquires alignment after
// LOSS_THRESH consecutive mismatches.
// Ports:
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   Enable       : permits pixel consumption
//   Throttle     : when 1, VideoReady is gated by LFSR backpressure
//   vid          : pixel stream (Video in, VideoReady out)
//   Locked       : aligned to block boundaries
//   ErrorCount   : saturating count of mismatched pixels
//   BlockCount   : wrapping count of completed blocks while locked
//   ErrorFlag    : sticky, set on the first mismatch
//
// state    | meaning
// IDLE     | out of reset, waiting for the first Enable
// ACQUIRE  | searching for an A->B or B->A colour edge
// LOCKED   | comparing pixels against the expected block colour
module video_pattern_checker
  import video_pattern_checker_pkg::*;
#(
  parameter int unsigned BLOCK_LEN     = DEF_BLOCK_LEN,
  parameter logic [23:0] COLOR_A       = DEF_COLOR_A,
  parameter logic [23:0] COLOR_B       = DEF_COLOR_B,
  parameter int unsigned LOSS_THRESH   = DEF_LOSS_THRESH,
  parameter bit          ALIGNED_START = 1'b1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic                   Throttle,
  video_pattern_checker_if.slave vid,
  output logic                   Locked,
  output logic [15:0]            ErrorCount,
  output logic [15:0]            BlockCount,
  output logic                   ErrorFlag
);

  localparam int IDX_W  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS_THRESH);

  logic              rnd;
  logic              accept;
  chk_state_t        state;
  chk_state_t        eff_state;
  logic [IDX_W-1:0]  idx;
  logic              exp_b;
  logic [MISS_W-1:0] miss;
  logic [MISS_W-1:0] miss_inc;
  logic [23:0]       pix;
  logic [23:0]       last_pix;
  logic [23:0]       exp_color;
  logic              last_valid;
  logic              pix_match;
  logic              is_edge;

  ready_lfsr u_ready_lfsr (
    .clk (Clock),
    .rst (Reset),
    .rnd (rnd)
  );

  // Reset is included so the handshake is quiet while reset is held.
  assign accept         = Enable & ~Reset & (~Throttle | rnd);
  assign vid.VideoReady = accept;

  assign pix       = vid.Video;
  assign exp_color = exp_b ? COLOR_B : COLOR_A;
  assign pix_match = (pix == exp_color);
  assign miss_inc  = miss + MISS_W'(1);

  // A colour edge needs the previous accepted pixel to be the other colour,
  // so a run of garbage followed by a mid-block colour cannot cause a
  // misaligned lock.
  assign is_edge = last_valid &
                   (((pix == COLOR_A) && (last_pix == COLOR_B)) ||
                    ((pix == COLOR_B) && (last_pix == COLOR_A)));

  // The pixel accepted on the first enabled cycle is handled by the state
  // being entered, so an aligned source loses no pixel to the IDLE exit.
  always_comb begin
    eff_state = state;
    if (state == ST_IDLE) begin
      eff_state = ALIGNED_START ? ST_LOCKED : ST_ACQUIRE;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      exp_b      <= 1'b0;
      miss       <= '0;
      last_pix   <= '0;
      last_valid <= 1'b0;
      Locked     <= 1'b0;
      ErrorCount <= '0;
      BlockCount <= '0;
      ErrorFlag  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && Enable) begin
        state  <= eff_state;
        Locked <= (eff_state == ST_LOCKED);
      end

      if (accept) begin
        if (eff_state == ST_ACQUIRE) begin
          last_pix   <= pix;
          last_valid <= 1'b1;
          if (is_edge) begin
            // The edge pixel is index 0 of its block.
            state  <= ST_LOCKED;
            Locked <= 1'b1;
            idx    <= IDX_W'(1);
            exp_b  <= (pix == COLOR_B);
            miss   <= '0;
          end
        end else if (eff_state == ST_LOCKED) begin
          if (idx == LAST_IDX) begin
            idx        <= '0;
            exp_b      <= ~exp_b;
            BlockCount <= BlockCount + 16'd1;
          end else begin
            idx <= idx + IDX_W'(1);
          end

          if (pix_match) begin
            miss <= '0;
          end else begin
            ErrorCount <= sat_inc16(ErrorCount);
            ErrorFlag  <= 1'b1;
            if (miss_inc == MISS_LIMIT) begin
              state      <= ST_ACQUIRE;
              Locked     <= 1'b0;
              miss       <= '0;
              last_valid <= 1'b0;
            end else begin
              miss <= miss_inc;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_checker.sv
// Directed bench for video_pattern_checker: an aligned checker driven by a
// block-pattern source with a reference model feeding a status scoreboard,
// plus an unaligned checker fed by a source started 50 pixels into a block.
module tb_video_pattern_checker;
  import video_pattern_checker_pkg::*;

  localparam int          BL = DEF_BLOCK_LEN;
  localparam int          LT = DEF_LOSS_THRESH;
  localparam logic [23:0] CA = DEF_COLOR_A;
  localparam logic [23:0] CB = DEF_COLOR_B;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0;
  logic        en_u = 1'b0;
  logic        thr = 1'b0;
  logic        lock_a, flag_a, lock_u, flag_u;
  logic [15:0] err_a, blk_a, err_u, blk_u;

  video_pattern_checker_if vif_a ();
  video_pattern_checker_if vif_u ();

  always #5 clk = ~clk;

  video_pattern_checker #(.ALIGNED_START(1'b1)) dut_a (
    .Clock      (clk),
    .Reset      (rst),
    .Enable     (en_a),
    .Throttle   (thr),
    .vid        (vif_a),
    .Locked     (lock_a),
    .ErrorCount (err_a),
    .BlockCount (blk_a),
    .ErrorFlag  (flag_a)
  );

  video_pattern_checker #(.ALIGNED_START(1'b0)) dut_u (
    .Clock      (clk),
    .Reset      (rst),
    .Enable     (en_u),
    .Throttle   (thr),
    .vid        (vif_u),
    .Locked     (lock_u),
    .ErrorCount (err_u),
    .BlockCount (blk_u),
    .ErrorFlag  (flag_u)
  );

  typedef struct packed {
    logic        locked;
    logic [15:0] err;
    logic [15:0] blk;
    logic        flag;
  } status_t;

  status_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model of dut_a
  int          m_state;
  int          m_idx;
  bit          m_exp_b;
  int          m_miss;
  logic [23:0] m_last;
  bit          m_last_v;
  int          m_err;
  bit          m_flag;
  int          m_blk;
  bit          m_locked;
  logic [7:0]  m_lfsr;

  // sources
  int          s_idx;
  bit          s_b;
  int          f_left;
  logic [23:0] f_val;
  int          acc_cnt;
  int          u_idx;
  bit          u_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register taps for x^8+x^6+x^5+x^4+1 with the new bit shifted in at bit 0.
  function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_idx    = 0;
    m_exp_b  = 1'b0;
    m_miss   = 0;
    m_last   = '0;
    m_last_v = 1'b0;
    m_err    = 0;
    m_flag   = 1'b0;
    m_blk    = 0;
    m_locked = 1'b0;
    m_lfsr   = 8'h01;
  endtask

  task automatic model_cycle(input bit en, input bit acc, input logic [23:0] p);
    status_t e;
    logic [23:0] want;
    if (m_state == M_IDLE && en) begin
      m_state  = M_LOCK;
      m_locked = 1'b1;
    end
    if (acc && m_state == M_ACQ) begin
      if (m_last_v && ((p == CA && m_last == CB) || (p == CB && m_last == CA))) begin
        m_state  = M_LOCK;
        m_locked = 1'b1;
        m_idx    = 1;
        m_exp_b  = (p == CB);
        m_miss   = 0;
      end
      m_last   = p;
      m_last_v = 1'b1;
    end else if (acc && m_state == M_LOCK) begin
      want = m_exp_b ? CB : CA;
      if (p == want) begin
        m_miss = 0;
      end else begin
        if (m_err < 65535) m_err++;
        m_flag = 1'b1;
        m_miss++;
      end
      m_idx++;
      if (m_idx == BL) begin
        m_idx   = 0;
        m_exp_b = !m_exp_b;
        m_blk   = (m_blk + 1) % 65536;
      end
      if (m_miss == LT) begin
        m_state  = M_ACQ;
        m_locked = 1'b0;
        m_miss   = 0;
        m_last_v = 1'b0;
      end
    end
    e.locked = m_locked;
    e.err    = 16'(m_err);
    e.blk    = 16'(m_blk);
    e.flag   = m_flag;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive pixels, check ready, run the model, then compare
  // the registered status one edge later against the scoreboard.
  task automatic step();
    bit      rdy_a;
    bit      rdy_u;
    status_t e;
    status_t o;
    vif_a.Video = (f_left > 0) ? f_val : (s_b ? CB : CA);
    vif_u.Video = u_b ? CB : CA;
    #3;
    rdy_a = en_a & ~rst & (~thr | m_lfsr[0]);
    rdy_u = en_u & ~rst & (~thr | m_lfsr[0]);
    chk("ready_a", 64'(vif_a.VideoReady), 64'(rdy_a));
    chk("ready_u", 64'(vif_u.VideoReady), 64'(rdy_u));
    model_cycle(en_a, rdy_a, vif_a.Video);
    if (rdy_a) begin
      acc_cnt++;
      if (f_left > 0) f_left--;
      s_idx++;
      if (s_idx == BL) begin
        s_idx = 0;
        s_b   = !s_b;
      end
    end
    if (rdy_u) begin
      u_idx++;
      if (u_idx == BL) begin
        u_idx = 0;
        u_b   = !u_b;
      end
    end
    @(posedge clk);
    m_lfsr = ref_lfsr(m_lfsr);
    #1;
    e        = exp_q.pop_front();
    o.locked = lock_a;
    o.err    = err_a;
    o.blk    = blk_a;
    o.flag   = flag_a;
    chk("status_a", 64'(o), 64'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready_a", 64'(vif_a.VideoReady), 64'(0));
    chk("rst_locked_a", 64'(lock_a), 64'(0));
    chk("rst_err_a", 64'(err_a), 64'(0));
    chk("rst_blk_a", 64'(blk_a), 64'(0));
    chk("rst_flag_a", 64'(flag_a), 64'(0));
    chk("rst_locked_u", 64'(lock_u), 64'(0));
    chk("rst_err_u", 64'(err_u), 64'(0));
    model_reset();
    exp_q.delete();
    s_idx  = 0;
    s_b    = 1'b0;
    f_left = 0;
    f_val  = '0;
    u_idx  = 50;
    u_b    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    acc_cnt = 0;
    vif_a.Video = CA;
    vif_u.Video = CA;
    do_reset();

    // continuous flow, aligned start
    en_a = 1'b1;
    thr  = 1'b0;
    repeat (1024) step();
    chk("flow_locked", 64'(lock_a), 64'(1));
    chk("flow_err", 64'(err_a), 64'(0));
    chk("flow_blk", 64'(blk_a), 64'(8));

    // LFSR backpressure
    thr     = 1'b1;
    acc_cnt = 0;
    repeat (4096) step();
    chk("thr_err", 64'(err_a), 64'(0));
    chk("thr_blk", 64'(blk_a), 64'(8 + acc_cnt / BL));

    // two isolated bad pixels mid-block
    thr = 1'b0;
    k = 0;
    while (s_idx != 30 && k < 300) begin step(); k++; end
    chk("bad2_reach", 64'(s_idx), 64'(30));
    f_val  = 24'h000000;
    f_left = 2;
    step();
    step();
    chk("bad2_err", 64'(err_a), 64'(2));
    chk("bad2_flag", 64'(flag_a), 64'(1));
    chk("bad2_locked", 64'(lock_a), 64'(1));
    repeat (10) step();
    chk("bad2_locked_hold", 64'(lock_a), 64'(1));

    // four consecutive bad pixels drop lock, then relock on the next edge
    k = 0;
    while (s_idx != 70 && k < 300) begin step(); k++; end
    chk("bad4_reach", 64'(s_idx), 64'(70));
    f_left = 4;
    repeat (3) step();
    chk("bad3_locked", 64'(lock_a), 64'(1));
    step();
    chk("bad4_unlocked", 64'(lock_a), 64'(0));
    chk("bad4_err", 64'(err_a), 64'(6));
    k = 0;
    while (lock_a !== 1'b1 && k < 200) begin step(); k++; end
    chk("relock", 64'(lock_a), 64'(1));
    chk("relock_at_edge", 64'(s_idx), 64'(1));
    repeat (300) step();
    chk("relock_err", 64'(err_a), 64'(6));
    chk("relock_locked", 64'(lock_a), 64'(1));

    // Enable low holds position; resuming keeps alignment
    en_a = 1'b0;
    repeat (20) step();
    en_a = 1'b1;
    repeat (200) step();
    chk("resume_err", 64'(err_a), 64'(6));

    // reset mid-block at index 60, then clean restart
    k = 0;
    while (m_idx != 60 && k < 300) begin step(); k++; end
    chk("idx60_reach", 64'(s_idx), 64'(60));
    do_reset();
    repeat (300) step();
    chk("post_rst_locked", 64'(lock_a), 64'(1));
    chk("post_rst_err", 64'(err_a), 64'(0));
    chk("post_rst_blk", 64'(blk_a), 64'(2));

    // unaligned start, source 50 pixels into the first A block
    en_a = 1'b0;
    en_u = 1'b1;
    repeat (78) step();
    chk("ua_before_edge", 64'(lock_u), 64'(0));
    step();
    chk("ua_locked", 64'(lock_u), 64'(1));
    chk("ua_err", 64'(err_u), 64'(0));
    repeat (127) step();
    chk("ua_blk", 64'(blk_u), 64'(1));
    chk("ua_err_end", 64'(err_u), 64'(0));
    chk("ua_flag_end", 64'(flag_u), 64'(0));
    chk("ua_locked_end", 64'(lock_u), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
